demux_buffered: RTL and testbench
=================================

DEMUX_BUFFERED -- requirements
Module: demux_buffered

Interface
REQ-001 The module SHALL import common_pkg::* and take parameter N, default 2, meaning the number of output streams (N >= 2).
REQ-002 The module SHALL take parameter W, default DEFAULT_D_W, meaning the width of each data beat.
REQ-003 The module SHALL take localparam L, equal to $clog2(N), meaning the number of select lines.
REQ-004 The module SHALL have one clock and an asynchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, asynchronous active-high reset).
REQ-005 The module SHALL have port s, input, L bits: destination select for the current input beat.
REQ-006 The module SHALL have port i_valid, input, 1 bit: the input beat is valid.
REQ-007 The module SHALL have port i_ready, output, 1 bit: the module accepts the input beat this cycle.
REQ-008 The module SHALL have port i, input, [W-1:0]: input data.
REQ-009 The module SHALL have port o_valid, output, [N-1:0]: per-output beat valid.
REQ-010 The module SHALL have port o_ready, input, [N-1:0]: per-output downstream ready.
REQ-011 The module SHALL have port o, output, [N-1:0][W-1:0]: per-output data.
REQ-012 The module SHALL have port err, output, 1 bit: sticky out-of-range-select flag.
REQ-013 The module SHALL have port drop_count, output, 8 bits: saturating count of dropped beats.

Function
REQ-014 A transfer SHALL occur on a port in any cycle where its valid and its ready are both 1 at the rising edge of clk.
REQ-015 Each output SHALL own a 2-entry FIFO, tracked by occupancy count c[k] in 0..2.
REQ-016 i_ready SHALL be 1 when s >= N, or when c[s] < 2.
- i_ready SHALL be derived only from registered state and s.
- i_ready SHALL NOT depend on o_ready or i_valid.
REQ-017 An accepted beat with s < N SHALL be written to the FIFO of output s. No other FIFO SHALL change on that push.
REQ-018 o_valid[k] SHALL equal (c[k] != 0). o[k] SHALL present the head entry of FIFO k.
REQ-019 Minimum latency SHALL be 1 cycle.
- A beat accepted at edge t into an empty FIFO appears on o_valid/o at edge t.
- It is consumable at edge t+1.
- There is no combinational i-to-o path.
REQ-020 Beats SHALL leave each output in the order they were accepted for that output.
- There is no ordering relation between different outputs.
REQ-021 Simultaneous push and pop on the same FIFO with c = 1 SHALL leave c = 1.
- The popped beat is the old head.
- The pushed beat becomes the new head.
REQ-022 Simultaneous push and pop on a FIFO with c = 2 SHALL NOT occur, because i_ready = 0 for that output.
- A pop alone reduces c to 1.
- The push is accepted in the following cycle.
REQ-023 A pop with c = 0 SHALL be impossible, because o_valid = 0.
- o_ready with o_valid = 0 SHALL have no effect.
REQ-024 Once o_valid[k] = 1, o_valid[k] and o[k] SHALL hold stable until the transfer on output k.
REQ-025 An accepted beat with s >= N (possible only when N is not a power of 2) SHALL be discarded.
- err SHALL be set to 1 at that edge and remain 1 until reset.
- drop_count SHALL increment by 1, saturating at 255.
REQ-026 Pops on different outputs SHALL be independent and may all occur in the same cycle as a push.
REQ-027 When i_valid = 0, s and i SHALL be ignored.

Reset
REQ-028 While rst = 1, and immediately on its assertion, the module SHALL force these values regardless of clk:
- all c[k] = 0, o_valid = 0, every o[k] = 0
- err = 0, drop_count = 0
REQ-029 While rst = 1, i_ready SHALL be 1, because all FIFOs are empty.
- No beat SHALL be accepted while rst = 1; a transfer at an edge with rst high is ignored.
REQ-030 Asserting rst mid-operation SHALL discard all buffered beats.
- The first edge after deassertion SHALL behave as if coming out of power-on.

Verification
REQ-031 Bench SHALL cover: N=2, W=32, o_ready=2'b00; push 0xA0,0xA1 to s=0 -> c[0]=2, o_valid=2'b01, o[0]=0xA0; third s=0 beat -> i_ready=0; push 0xB0 to s=1 accepted.
REQ-032 Bench SHALL cover: c[0]=1 holding 0xA0, o_ready[0]=1, push 0xA2 to s=0 same cycle -> next cycle c[0]=1, o[0]=0xA2; 0xA0 delivered once.
REQ-033 Bench SHALL cover: random s, i_valid, o_ready for 10000 cycles, N=2 -> per-output scoreboard exact order, no loss/duplication, o stable while o_valid & !o_ready.
REQ-034 Bench SHALL cover: N=3, 300 beats with s=3 -> all accepted (i_ready=1), none appear on o_valid, err=1 after the first, drop_count=255 saturated.
REQ-035 Bench SHALL cover: both FIFOs full, assert rst between clock edges -> o_valid=2'b00, err=0, drop_count=0 immediately; after release push 0xC0 to s=1 -> o[1]=0xC0 next edge.

Source files
------------

// File: rtl/common_pkg.sv
// ============================================================================
// Module  : common_pkg
// Purpose : Shared defaults for the stream-handling blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package common_pkg;
    localparam int DEFAULT_D_W = 32;
endpackage

`default_nettype wire

// File: rtl/demux_buffered.sv
// ============================================================================
// Module  : demux_buffered
// Purpose : Routes one valid/ready input stream to N outputs, each with a
//           2-entry FIFO; out-of-range selects are dropped and counted.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_buffered
    import common_pkg::*;
#(
    parameter int N = 2,
    parameter int W = DEFAULT_D_W,
    localparam int L = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [L-1:0]        s,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic [W-1:0]        i,
    output logic [N-1:0]        o_valid,
    input  logic [N-1:0]        o_ready,
    output logic [N-1:0][W-1:0] o,
    output logic                err,
    output logic [7:0]          drop_count
);

    logic [N-1:0] w_hit;
    logic [N-1:0] w_full;
    logic         w_drop;
    logic         r_err;
    logic [7:0]   r_drop_count;

    // An unmatched select never blocks, so its beat is always taken and dropped.
    assign i_ready = ~|(w_hit & w_full);
    assign w_drop  = i_valid & ~|w_hit;

    generate
        for (genvar k = 0; k < N; k++) begin : g_fifo
            localparam logic [L-1:0] C_IDX = L'(k);

            logic [1:0]   r_cnt;
            logic [W-1:0] r_head;
            logic [W-1:0] r_tail;
            logic         w_push;
            logic         w_pop;

            assign w_hit[k]   = (s == C_IDX);
            assign w_full[k]  = (r_cnt == 2'd2);
            assign w_push     = i_valid & w_hit[k] & ~w_full[k];
            assign w_pop      = o_ready[k] & (r_cnt != 2'd0);
            assign o_valid[k] = (r_cnt != 2'd0);
            assign o[k]       = r_head;

            // Head only moves on a pop or a push into an empty FIFO, which
            // keeps o[k] stable while the consumer stalls.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt  <= 2'd0;
                    r_head <= '0;
                    r_tail <= '0;
                end else begin
                    case ({w_push, w_pop})
                        2'b10: begin
                            if (r_cnt == 2'd0) begin
                                r_head <= i;
                            end else begin
                                r_tail <= i;
                            end
                            r_cnt <= r_cnt + 2'd1;
                        end
                        2'b01: begin
                            r_head <= r_tail;
                            r_cnt  <= r_cnt - 2'd1;
                        end
                        2'b11: begin
                            // Only reachable with one entry: new beat replaces the popped head.
                            r_head <= i;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err        <= 1'b0;
            r_drop_count <= 8'd0;
        end else if (w_drop) begin
            r_err <= 1'b1;
            if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign err        = r_err;
    assign drop_count = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_demux_buffered.sv
// ============================================================================
// Module  : tb_demux_buffered
// Purpose : Self-checking bench for demux_buffered (N=2 and N=3 instances).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_buffered;

    logic clk;
    logic rst;

    logic              s2;
    logic              iv2;
    logic              ir2;
    logic [31:0]       din2;
    logic [1:0]        ov2;
    logic [1:0]        ordy2;
    logic [1:0][31:0]  o2;
    logic              err2;
    logic [7:0]        dc2;

    logic [1:0]        s3;
    logic              iv3;
    logic              ir3;
    logic [31:0]       din3;
    logic [2:0]        ov3;
    logic [2:0]        ordy3;
    logic [2:0][31:0]  o3;
    logic              err3;
    logic [7:0]        dc3;

    int n_checks;
    int n_errors;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    demux_buffered #(.N(2), .W(32)) dut2 (
        .clk(clk), .rst(rst), .s(s2), .i_valid(iv2), .i_ready(ir2), .i(din2),
        .o_valid(ov2), .o_ready(ordy2), .o(o2), .err(err2), .drop_count(dc2)
    );

    demux_buffered #(.N(3), .W(32)) dut3 (
        .clk(clk), .rst(rst), .s(s3), .i_valid(iv3), .i_ready(ir3), .i(din3),
        .o_valid(ov3), .o_ready(ordy3), .o(o3), .err(err3), .drop_count(dc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sz0, sz1;
        logic exp_rdy;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        s2 = 1'b0; iv2 = 1'b0; din2 = '0; ordy2 = '0;
        s3 = 2'd0; iv3 = 1'b0; din3 = '0; ordy3 = '0;

        repeat (2) tick();
        check("rst_ovalid", 64'(ov2), 64'd0);
        check("rst_err", 64'(err2), 64'd0);
        check("rst_drop", 64'(dc2), 64'd0);
        check("rst_iready", 64'(ir2), 64'd1);
        check("rst_o0", 64'(o2[0]), 64'd0);
        rst = 1'b0;
        tick();

        // Out-of-range select on the N=3 instance.
        s3 = 2'd3; iv3 = 1'b1; ordy3 = 3'b111;
        for (int b = 0; b < 300; b++) begin
            din3 = 32'(b);
            #1;
            check("drop_iready", 64'(ir3), 64'd1);
            @(posedge clk);
            #1;
            check("drop_ovalid", 64'(ov3), 64'd0);
            if (b == 0) begin
                check("drop_err_first", 64'(err3), 64'd1);
                check("drop_cnt_first", 64'(dc3), 64'd1);
            end
        end
        check("drop_cnt_sat", 64'(dc3), 64'd255);
        check("drop_err_sticky", 64'(err3), 64'd1);
        iv3 = 1'b0; ordy3 = '0;

        // Fill FIFO 0, then see it block while FIFO 1 still accepts.
        ordy2 = 2'b00; iv2 = 1'b1; s2 = 1'b0; din2 = 32'hA0;
        tick();
        din2 = 32'hA1;
        tick();
        check("fill_ovalid", 64'(ov2), 64'h1);
        check("fill_head", 64'(o2[0]), 64'hA0);
        din2 = 32'hA2;
        #1;
        check("full_iready", 64'(ir2), 64'd0);
        tick();
        check("full_head_hold", 64'(o2[0]), 64'hA0);
        s2 = 1'b1; din2 = 32'hB0;
        #1;
        check("other_iready", 64'(ir2), 64'd1);
        tick();
        check("other_ovalid", 64'(ov2), 64'h3);
        check("other_head", 64'(o2[1]), 64'hB0);
        din2 = 32'hB1;
        tick();
        check("both_full_iready", 64'(ir2), 64'd0);
        iv2 = 1'b0;

        // Asynchronous reset between edges with both FIFOs full.
        #3;
        rst = 1'b1;
        #1;
        check("async_ovalid", 64'(ov2), 64'd0);
        check("async_o1", 64'(o2[1]), 64'd0);
        check("async_err3", 64'(err3), 64'd0);
        check("async_drop3", 64'(dc3), 64'd0);
        check("async_iready", 64'(ir2), 64'd1);
        iv2 = 1'b1; s2 = 1'b0; din2 = 32'hDEAD;
        tick();
        rst = 1'b0; iv2 = 1'b0;
        #1;
        check("no_accept_in_rst", 64'(ov2), 64'd0);
        iv2 = 1'b1; s2 = 1'b1; din2 = 32'hC0;
        tick();
        check("post_rst_ovalid", 64'(ov2), 64'h2);
        check("post_rst_head", 64'(o2[1]), 64'hC0);
        iv2 = 1'b0; ordy2 = 2'b10;
        tick();
        ordy2 = 2'b00;
        check("post_rst_drain", 64'(ov2), 64'd0);

        // Push and pop together on a single-entry FIFO.
        iv2 = 1'b1; s2 = 1'b0; din2 = 32'hA0;
        tick();
        check("pp_head_before", 64'(o2[0]), 64'hA0);
        din2 = 32'hA2; ordy2 = 2'b01;
        #1;
        check("pp_iready", 64'(ir2), 64'd1);
        tick();
        check("pp_ovalid", 64'(ov2[0]), 64'd1);
        check("pp_head_after", 64'(o2[0]), 64'hA2);
        iv2 = 1'b0;
        tick();
        check("pp_once", 64'(ov2), 64'd0);
        ordy2 = 2'b00;

        // Randomised traffic against a per-output scoreboard.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            iv2   = 1'($urandom_range(0, 1));
            s2    = 1'($urandom_range(0, 1));
            din2  = $urandom;
            ordy2 = 2'($urandom_range(0, 3));
            #1;
            sz0 = q0.size();
            sz1 = q1.size();
            exp_rdy = (s2 == 1'b0) ? (sz0 < 2) : (sz1 < 2);
            check("rand_iready", 64'(ir2), 64'(exp_rdy));
            check("rand_ovalid0", 64'(ov2[0]), 64'(sz0 != 0));
            check("rand_ovalid1", 64'(ov2[1]), 64'(sz1 != 0));
            if (sz0 != 0) check("rand_data0", 64'(o2[0]), 64'(q0[0]));
            if (sz1 != 0) check("rand_data1", 64'(o2[1]), 64'(q1[0]));
            if (ordy2[0] && sz0 != 0) void'(q0.pop_front());
            if (ordy2[1] && sz1 != 0) void'(q1.pop_front());
            if (iv2 && exp_rdy) begin
                if (s2 == 1'b0) q0.push_back(din2);
                else            q1.push_back(din2);
            end
            tick();
        end
        iv2 = 1'b0; ordy2 = 2'b00;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
